bitonic_16_topk_drain: RTL and testbench

- Consumer at the output end of the 16-input bitonic sorter pipeline.
- Accepts one sorted 16-element vector per handshake, along with its sort-direction flag and a per-vector K.
- Serialises the K largest elements, largest first, onto a valid/ready stream.
- Has a 2-slot buffer (active + pending), so back-to-back vectors stream with no bubble between them.

---
 rtl/bitonic_16_topk_drain.sv | 135 +++++++++++++
 tb/tb_bitonic_16_topk_drain.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bitonic_16_topk_drain.sv
// Top-K drain stage for the 16-input bitonic sorter: takes a sorted vector plus K and
// streams the K largest elements, largest first, using an active slot and a pending slot.
module bitonic_16_topk_drain #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 16,
  parameter int KW         = 5
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 sign_ctrl_i,
  input  logic [KW-1:0]        k_i,
  input  logic [DATAWIDTH-1:0] x_i [DATALENGTH-1:0],
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] y_o,
  output logic [KW-1:0]        rank_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam int IDXW = $clog2(DATALENGTH);
  localparam logic [KW-1:0] K_MAX = KW'(DATALENGTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [KW-1:0]        rank_q, rank_d;
  logic [KW-1:0]        act_k_q, act_k_d;
  logic                 act_sign_q, act_sign_d;
  logic [DATAWIDTH-1:0] act_x_q [DATALENGTH-1:0];
  logic [DATAWIDTH-1:0] act_x_d [DATALENGTH-1:0];
  logic                 pend_full_q, pend_full_d;
  logic [KW-1:0]        pend_k_q, pend_k_d;
  logic                 pend_sign_q, pend_sign_d;
  logic [DATAWIDTH-1:0] pend_x_q [DATALENGTH-1:0];
  logic [DATAWIDTH-1:0] pend_x_d [DATALENGTH-1:0];

  logic          accept, load_new, fire, last_beat, act_free;
  logic [KW-1:0] k_eff;
  logic [IDXW-1:0] idx, sel_idx;

  assign ready_o   = rstn_i & ~pend_full_q;
  assign valid_o   = (state_q == S_DRAIN);
  assign last_beat = valid_o && (rank_q == act_k_q - KW'(1));
  assign last_o    = last_beat;
  assign busy_o    = valid_o | pend_full_q;

  assign idx     = rank_q[IDXW-1:0];
  assign sel_idx = act_sign_q ? idx : IDXW'(DATALENGTH - 1) - idx;
  // Outputs are forced to zero when idle so the unreset data arrays never leak out.
  assign y_o    = valid_o ? act_x_q[sel_idx] : '0;
  assign rank_o = valid_o ? rank_q : '0;

  assign k_eff    = (k_i > K_MAX) ? K_MAX : k_i;
  assign accept   = valid_i && ready_o;
  assign load_new = accept && (k_eff != '0);
  assign fire     = valid_o && ready_i;
  assign act_free = (state_q == S_IDLE) || (fire && last_beat);

  always_comb begin
    state_d     = state_q;
    rank_d      = rank_q;
    act_k_d     = act_k_q;
    act_sign_d  = act_sign_q;
    act_x_d     = act_x_q;
    pend_full_d = pend_full_q;
    pend_k_d    = pend_k_q;
    pend_sign_d = pend_sign_q;
    pend_x_d    = pend_x_q;

    if (act_free) begin
      if (pend_full_q) begin
        // Pending promotes to active; a simultaneous new vector takes its place.
        state_d     = S_DRAIN;
        rank_d      = '0;
        act_k_d     = pend_k_q;
        act_sign_d  = pend_sign_q;
        act_x_d     = pend_x_q;
        pend_full_d = load_new;
        if (load_new) begin
          pend_k_d    = k_eff;
          pend_sign_d = sign_ctrl_i;
          pend_x_d    = x_i;
        end
      end else if (load_new) begin
        state_d    = S_DRAIN;
        rank_d     = '0;
        act_k_d    = k_eff;
        act_sign_d = sign_ctrl_i;
        act_x_d    = x_i;
      end else begin
        state_d = S_IDLE;
        rank_d  = '0;
      end
    end else begin
      if (fire) rank_d = rank_q + KW'(1);
      if (load_new) begin
        pend_full_d = 1'b1;
        pend_k_d    = k_eff;
        pend_sign_d = sign_ctrl_i;
        pend_x_d    = x_i;
      end
    end
  end

  // NOTE: control state is reset; the data arrays are not, since they are only
  // observed once a slot is marked occupied and resetting them costs a mux per bit.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      rank_q      <= '0;
      act_k_q     <= '0;
      act_sign_q  <= 1'b0;
      pend_full_q <= 1'b0;
      pend_k_q    <= '0;
      pend_sign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rank_q      <= rank_d;
      act_k_q     <= act_k_d;
      act_sign_q  <= act_sign_d;
      pend_full_q <= pend_full_d;
      pend_k_q    <= pend_k_d;
      pend_sign_q <= pend_sign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    act_x_q  <= act_x_d;
    pend_x_q <= pend_x_d;
  end

endmodule

// File: tb/tb_bitonic_16_topk_drain.sv
// Directed bench for bitonic_16_topk_drain: hand-computed beats checked one cycle at a time.
module tb_bitonic_16_topk_drain;

  logic       clk = 1'b0;
  logic       rstn, valid_i, ready_o, sign, valid_o, ready_i, last_o, busy_o;
  logic [4:0] k, rank_o;
  logic [7:0] x [15:0];
  logic [7:0] y_o;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitonic_16_topk_drain dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
    .sign_ctrl_i(sign), .k_i(k), .x_i(x), .valid_o(valid_o), .ready_i(ready_i),
    .y_o(y_o), .rank_o(rank_o), .last_o(last_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int base, input int step);
    for (int j = 0; j < 16; j++) x[j] = 8'(base + step * j);
  endtask

  task automatic beat(input string tag, input int yv, input int rv, input bit lv);
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_y"}, y_o, yv);
    check({tag, "_rank"}, rank_o, rv);
    check({tag, "_last"}, last_o, lv);
  endtask

  initial begin
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; sign = 1'b0; k = '0;
    set_x(0, 1);
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_y", y_o, 0);
    check("rst_rank", rank_o, 0);
    check("rst_last", last_o, 0);
    rstn = 1'b1;
    #1 check("post_rst_ready", ready_o, 1);

    // Ascending, k=4: 15,14,13,12
    set_x(0, 1); sign = 1'b0; k = 5'd4; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat("asc", 15 - i, i, i == 3);
      tick();
    end
    check("asc_done_valid", valid_o, 0);
    check("asc_done_busy", busy_o, 0);

    // Descending, k=3: 100,99,98
    set_x(100, -1); sign = 1'b1; k = 5'd3; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("desc", 100 - i, i, i == 2);
      tick();
    end
    check("desc_done_valid", valid_o, 0);

    // Back-to-back A (asc k=2) then B (desc k=2): 15,14,100,99 with no gap
    set_x(0, 1); sign = 1'b0; k = 5'd2; valid_i = 1'b1;
    tick();
    beat("b2b_a0", 15, 0, 0);
    set_x(100, -1); sign = 1'b1; k = 5'd2; valid_i = 1'b1;
    check("b2b_ready_b", ready_o, 1);
    tick(); valid_i = 1'b0;
    beat("b2b_a1", 14, 1, 1);
    check("b2b_ready_drop", ready_o, 0);
    check("b2b_busy", busy_o, 1);
    tick();
    beat("b2b_b0", 100, 0, 0);
    check("b2b_ready_back", ready_o, 1);
    tick();
    beat("b2b_b1", 99, 1, 1);
    tick();
    check("b2b_done_valid", valid_o, 0);

    // Backpressure: C (x=2j asc, k=3), ready_i 1,0,0,1,0,1; D and E queued behind it
    set_x(0, 2); sign = 1'b0; k = 5'd3; valid_i = 1'b1;
    tick();
    beat("bp_c0", 30, 0, 0);
    ready_i = 1'b1;
    set_x(0, 1); sign = 1'b0; k = 5'd1; valid_i = 1'b1;   // D
    tick();
    set_x(200, -1); sign = 1'b1; k = 5'd1; valid_i = 1'b1; // E
    ready_i = 1'b0;
    beat("bp_c1", 28, 1, 0);
    check("bp_full_ready0", ready_o, 0);
    tick();
    beat("bp_c1_hold_a", 28, 1, 0);
    check("bp_full_ready1", ready_o, 0);
    tick();
    beat("bp_c1_hold_b", 28, 1, 0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    beat("bp_c2", 26, 2, 1);
    check("bp_full_ready2", ready_o, 0);
    tick();
    beat("bp_c2_hold", 26, 2, 1);
    ready_i = 1'b1;
    tick();
    beat("bp_d0", 15, 0, 1);
    check("bp_ready_e", ready_o, 1);
    tick(); valid_i = 1'b0;
    beat("bp_e0", 200, 0, 1);
    tick();
    check("bp_done_valid", valid_o, 0);
    check("bp_done_busy", busy_o, 0);

    // k=0 is dropped; k=20 clamps to 16 beats
    set_x(0, 1); sign = 1'b0; k = 5'd0; valid_i = 1'b1;
    check("k0_ready", ready_o, 1);
    tick(); valid_i = 1'b0;
    check("k0_valid", valid_o, 0);
    check("k0_busy", busy_o, 0);
    set_x(1, 3); sign = 1'b0; k = 5'd20; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat("k20", 3 * (15 - i) + 1, i, i == 15);
      tick();
    end
    check("k20_done_valid", valid_o, 0);

    // Reset mid-drain with pending full
    set_x(0, 1); sign = 1'b0; k = 5'd8; valid_i = 1'b1;
    tick();
    beat("rm_f0", 15, 0, 0);
    set_x(50, 1); k = 5'd2; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    beat("rm_f1", 14, 1, 0);
    check("rm_pending_full", ready_o, 0);
    rstn = 1'b0;
    tick();
    check("rm_valid", valid_o, 0);
    check("rm_busy", busy_o, 0);
    check("rm_ready_in_rst", ready_o, 0);
    check("rm_y", y_o, 0);
    rstn = 1'b1;
    #1 check("rm_ready_after", ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rm_no_stale", valid_o, 0);
    end
    check("rm_busy_after", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
